xray_frame_sequencer: RTL and testbench



---
 rtl/xray_frame_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_xray_frame_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/xray_frame_sequencer.sv
// xray_frame_sequencer
// ---------------------------------------------------------------------------
// Drives one X-ray sensor frame from the system clock. A frame has three
// phases: a sensor reset phase (SENRST high), an integration phase and a
// pixel readout phase. SENCLK is generated only while a frame runs. Each
// readout period issues one ADC SAMPLE strobe together with its pixel index.
// In continuous mode the next frame follows directly after the current one.
//
// Ports
//   CLK        in   system clock (100 MHz nominal)
//   RST        in   synchronous reset, active-high, overrides all inputs
//   START      in   begin a frame (looked at only while idle)
//   CONT       in   continuous mode (looked at in the DONE cycle)
//   ABORT      in   terminate the current frame, back to idle
//   SENCLK     out  sensor pixel clock
//   SENRST     out  sensor reset
//   SAMPLE     out  one-cycle ADC capture strobe
//   PIX_IDX    out  index of the pixel being sampled
//   BUSY       out  high whenever the sequencer is not idle
//   FRAME_DONE out  one-cycle pulse at frame end
//
// SAMPLE and FRAME_DONE are plain single-cycle strobes. The consumer must
// capture them on the cycle they are high, because there is no back-pressure.
// The FSM state (state_q) is a named enum register so that it can be
// observed hierarchically.
// ---------------------------------------------------------------------------
module xray_frame_sequencer #(
  parameter int HALF_PER   = 1250,
  parameter int RST_PER    = 8,
  parameter int INT_PER    = 256,
  parameter int NPIX       = 64,
  parameter int SAMPLE_DLY = 625,
  parameter int IDXW       = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            CONT,
  input  logic            ABORT,
  output logic            SENCLK,
  output logic            SENRST,
  output logic            SAMPLE,
  output logic [IDXW-1:0] PIX_IDX,
  output logic            BUSY,
  output logic            FRAME_DONE
);

  localparam int HCW  = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int PMAX = (RST_PER > INT_PER) ? ((RST_PER > NPIX) ? RST_PER : NPIX)
                                            : ((INT_PER > NPIX) ? INT_PER : NPIX);
  localparam int PCW  = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_INTEG   = 3'd2,
    S_READOUT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [HCW-1:0]    hc_q, hc_d;
  logic [PCW-1:0]    pc_q, pc_d;
  logic              senclk_q, senclk_d;
  logic              senrst_q, senrst_d;
  logic              sample_q, sample_d;
  logic [IDXW-1:0]   pix_q, pix_d;
  logic              busy_q, busy_d;
  logic              fdone_q, fdone_d;

  logic              running;
  logic              hc_wrap;
  logic              pend;

  assign running = (state_q == S_RESET) || (state_q == S_INTEG) || (state_q == S_READOUT);
  assign hc_wrap = (hc_q == HCW'(HALF_PER - 1));
  // A period ends when SENCLK toggles from high to low.
  assign pend    = running && hc_wrap && senclk_q;

  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    pc_d     = pc_q;
    senclk_d = senclk_q;
    senrst_d = senrst_q;
    sample_d = 1'b0;
    pix_d    = pix_q;
    busy_d   = busy_q;
    fdone_d  = 1'b0;

    if (running) begin
      if (hc_wrap) begin
        hc_d     = '0;
        senclk_d = ~senclk_q;
      end else begin
        hc_d = hc_q + 1'b1;
      end
      if (pend) begin
        pc_d = pc_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_RESET;
          senrst_d = 1'b1;
          busy_d   = 1'b1;
          hc_d     = '0;
          pc_d     = '0;
          senclk_d = 1'b0;
        end
      end
      S_RESET: begin
        if (pend && (pc_q == PCW'(RST_PER - 1))) begin
          state_d  = S_INTEG;
          senrst_d = 1'b0;
          pc_d     = '0;
        end
      end
      S_INTEG: begin
        if (pend && (pc_q == PCW'(INT_PER - 1))) begin
          state_d = S_READOUT;
          pc_d    = '0;
        end
      end
      S_READOUT: begin
        // hc restarts at 0 on the rising edge of SENCLK. hc==SAMPLE_DLY-1
        // therefore registers the strobe SAMPLE_DLY cycles after that edge.
        sample_d = senclk_q && (hc_q == HCW'(SAMPLE_DLY - 1));
        if (pend) begin
          pix_d = pix_q + 1'b1;
          if (pc_q == PCW'(NPIX - 1)) begin
            state_d = S_DONE;
            pc_d    = '0;
            fdone_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        senclk_d = 1'b0;
        hc_d     = '0;
        pc_d     = '0;
        pix_d    = '0;
        if (CONT) begin
          state_d  = S_RESET;
          senrst_d = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ABORT wins over START/CONT. When ABORT and START arrive together in
    // IDLE, the sequencer therefore stays idle.
    if (ABORT) begin
      state_d  = S_IDLE;
      hc_d     = '0;
      pc_d     = '0;
      senclk_d = 1'b0;
      senrst_d = 1'b0;
      sample_d = 1'b0;
      pix_d    = '0;
      busy_d   = 1'b0;
      fdone_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      hc_q     <= '0;
      pc_q     <= '0;
      senclk_q <= 1'b0;
      senrst_q <= 1'b0;
      sample_q <= 1'b0;
      pix_q    <= '0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      pc_q     <= pc_d;
      senclk_q <= senclk_d;
      senrst_q <= senrst_d;
      sample_q <= sample_d;
      pix_q    <= pix_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
    end
  end

  assign SENCLK     = senclk_q;
  assign SENRST     = senrst_q;
  assign SAMPLE     = sample_q;
  assign PIX_IDX    = pix_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = fdone_q;

endmodule

// File: tb/tb_xray_frame_sequencer.sv
// Testbench for xray_frame_sequencer, built with small parameters. The
// reference model tracks only whether a frame is active and how many cycles
// have passed since its start edge. Every expected output comes from that
// frame time by arithmetic.
module tb_xray_frame_sequencer;

  localparam int H  = 4;
  localparam int R  = 2;
  localparam int I  = 3;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int W  = 8;
  localparam int P  = 2 * H;
  localparam int RO = P * (R + I);
  localparam int F  = P * (R + I + N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic abort = 1'b0;

  logic         senclk, senrst, sample, busy, fdone;
  logic [W-1:0] pix;

  always #5 clk = ~clk;

  xray_frame_sequencer #(
    .HALF_PER(H), .RST_PER(R), .INT_PER(I), .NPIX(N), .SAMPLE_DLY(D), .IDXW(W)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .CONT(cont), .ABORT(abort),
    .SENCLK(senclk), .SENRST(senrst), .SAMPLE(sample), .PIX_IDX(pix),
    .BUSY(busy), .FRAME_DONE(fdone)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit m_act = 1'b0;
  int m_t   = 0;

  // ---------------- observation statistics ----------------
  int   cyc = 0;
  int   rise_cyc, first_smp, smp_cnt, fd_cnt, fd_last, fd_prev, rst_hi, clk_rises;
  logic prev_senrst = 1'b0;
  logic prev_senclk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    rise_cyc  = -1000;
    first_smp = -1000;
    smp_cnt   = 0;
    fd_cnt    = 0;
    fd_last   = -1000;
    fd_prev   = -1000;
    rst_hi    = 0;
    clk_rises = 0;
  endtask

  // Advance one clock. The model consumes the inputs seen at this edge, and
  // the outputs are compared 1 time unit later.
  task automatic tick();
    bit e_senrst, e_senclk, e_sample, e_fd;
    int e_pix;
    @(posedge clk);
    if (rst) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (abort) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1;
        m_t   = 0;
      end
    end else if (m_t == F) begin
      if (cont) m_t = 0;
      else m_act = 1'b0;
    end else begin
      m_t++;
    end
    #1;
    cyc++;
    e_senrst = m_act && (m_t < P * R);
    e_senclk = m_act && (m_t < F) && (((m_t / H) % 2) == 1);
    e_sample = m_act && (m_t >= RO) && (m_t < F) && (((m_t - RO) % P) == H + D);
    e_fd     = m_act && (m_t == F);
    e_pix    = (m_act && (m_t >= RO)) ? (m_t - RO) / P : 0;
    chk("senrst",     32'(senrst), 32'(e_senrst));
    chk("senclk",     32'(senclk), 32'(e_senclk));
    chk("sample",     32'(sample), 32'(e_sample));
    chk("frame_done", 32'(fdone),  32'(e_fd));
    chk("busy",       32'(busy),   32'(m_act));
    chk("pix_idx",    32'(pix),    32'(e_pix));
    if (senrst === 1'b1 && prev_senrst !== 1'b1) rise_cyc = cyc;
    if (senrst === 1'b1) rst_hi++;
    if (senclk === 1'b1 && prev_senclk !== 1'b1) clk_rises++;
    if (sample === 1'b1) begin
      smp_cnt++;
      if (smp_cnt == 1) first_smp = cyc;
    end
    if (fdone === 1'b1) begin
      fd_cnt++;
      fd_prev = fd_last;
      fd_last = cyc;
    end
    prev_senrst = senrst;
    prev_senclk = senclk;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_single_frame(input string tag);
    chk({tag, "_fd_count"},     fd_cnt, 1);
    chk({tag, "_fd_offset"},    fd_last - rise_cyc, F);
    chk({tag, "_first_sample"}, first_smp - rise_cyc, RO + H + D);
    chk({tag, "_sample_count"}, smp_cnt, N);
    chk({tag, "_senrst_len"},   rst_hi, P * R);
    chk({tag, "_senclk_rises"}, clk_rises, F / P);
    chk({tag, "_busy_end"},     32'(busy), 0);
  endtask

  // ---------------- directed sequence + random phase ----------------
  initial begin
    bit hit;
    clear_stats();

    // 1: reset, then a long idle stretch
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    clear_stats();
    ticks(50);
    chk("idle_senclk_rises", clk_rises, 0);
    chk("idle_busy_seen",    rst_hi, 0);

    // 2: single frame
    clear_stats();
    pulse_start();
    ticks(80);
    check_single_frame("single");

    // 3: continuous mode, two back-to-back frames
    ticks($urandom_range(1, 8));
    clear_stats();
    cont = 1'b1;
    pulse_start();
    ticks(100);
    cont = 1'b0;
    ticks(60);
    chk("cont_fd_count",     fd_cnt, 2);
    chk("cont_fd_gap",       fd_last - fd_prev, F + 1);
    chk("cont_sample_count", smp_cnt, 2 * N);
    chk("cont_senrst_len",   rst_hi, 2 * P * R);

    // 4: abort after two samples, then a clean frame
    ticks($urandom_range(1, 10));
    clear_stats();
    pulse_start();
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      tick();
      if (smp_cnt == 2) hit = 1'b1;
    end
    chk("abort_reached_two_samples", 32'(hit), 1);
    ticks($urandom_range(0, 3));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ticks(30);
    chk("abort_no_fd",      fd_cnt, 0);
    chk("abort_no_samples", smp_cnt, 2);
    clear_stats();
    pulse_start();
    ticks(80);
    check_single_frame("after_abort");

    // 5: START pulses during a frame are ignored
    clear_stats();
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      ticks(9);
      pulse_start();
    end
    ticks(15);
    chk("ignored_start_fd_count", fd_cnt, 1);
    chk("ignored_start_samples",  smp_cnt, N);

    // 6: RST during integration, then a fresh frame
    clear_stats();
    pulse_start();
    ticks(24);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(5);
    chk("rst_mid_no_fd", fd_cnt, 0);
    clear_stats();
    pulse_start();
    ticks(80);
    check_single_frame("after_rst");

    // 7: random mix of START/CONT/ABORT/RST against the model
    for (int k = 0; k < 2000; k++) begin
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 199) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) cont = ~cont;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    cont  = 1'b0;
    ticks(100);
    chk("final_idle_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
